nco_phase_acc: RTL and testbench
================================

# nco_phase_acc

Numerically controlled phase accumulator that generates the 21-bit phase word consumed by the `sine` lookup/interpolation stage. On each sample strobe it advances a 32-bit accumulator by a frequency tuning word (FTW), adds a static phase offset and presents the top 21 bits as `phase_out`. FTW changes go through a valid/ready handshake and are applied phase-continuously at the next accumulator wrap. A start/stop FSM guarantees that output always ends on a whole cycle.

## Interface
- `ACC_W`, 32: accumulator width; must be ≥ PHASE_W + 8.
- `PHASE_W`, 21: output phase width; must match the `sine` phase input.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sample strobe; one accumulator step per cycle with `en`=1.
- `start` in 1: pulse; IDLE→RUN.
- `stop` in 1: pulse; request a stop at the next wrap.
- `ftw_in` in ACC_W: new tuning word.
- `ftw_valid` in 1: `ftw_in` valid.
- `ftw_ready` out 1: shadow register empty; transfer occurs when valid&&ready.
- `phase_offset` in PHASE_W: static offset, added at output; sampled every cycle.
- `phase_out` out PHASE_W: phase to `sine`.
- `phase_valid` out 1: one-cycle pulse per accepted strobe in RUN/STOPPING.
- `wrap` out 1: accumulator carry-out on this step; aligned with `phase_valid`.
- `busy` out 1: state ≠ IDLE.

## Operation
- Registers: `acc`[ACC_W], `ftw_act`[ACC_W], `ftw_shd`[ACC_W], `shd_full`, state.
- FSM states:
  - IDLE: `acc` held at 0 and no strobes are consumed. `start` → RUN.
  - RUN: on `stop`, go to STOPPING.
  - STOPPING: on a step with carry, go to IDLE. `acc` is forced to 0 and that step's phase_valid/wrap are still emitted.
- `start` in RUN/STOPPING is ignored. `stop` in IDLE/STOPPING is ignored. `start` and `stop` together in IDLE: `start` wins and `stop` is dropped.
- Step, when `en` in RUN/STOPPING: `{carry, acc} <= acc + ftw_act` (ACC_W+1-bit sum, modulo 2^ACC_W).
- Output: `phase_out <= (acc_next + (phase_offset << (ACC_W-PHASE_W)) + dith)[ACC_W-1 -: PHASE_W]`, modulo 2^ACC_W. `dith` = 0 unless the dither macro is enabled.
- FTW handshake: `ftw_ready = !shd_full`. On transfer: `ftw_shd <= ftw_in` and `shd_full <= 1`.
- Applying the shadow: on a step with carry=1, or in IDLE on any cycle, `ftw_act <= ftw_shd` and `shd_full <= 0`. The new FTW is used from the next step.
- Transfer and apply in the same cycle: apply the old shadow and load the new one; `shd_full` stays 1.
- `phase_offset` changes take effect at the next step and are not retimed.

## Timing
- Latency: `en` at cycle n → `phase_out`/`phase_valid`/`wrap` valid at n+1. `phase_valid` and `wrap` are single-cycle pulses.
- Throughput: one step per cycle; back-to-back `en` is allowed.
- Reset values: `acc`=0, `ftw_act`=0, `ftw_shd`=0, `shd_full`=0, state=IDLE, `phase_out`=0, `phase_valid`=0, `wrap`=0, `busy`=0, `ftw_ready`=1. LFSR = 8'hA5.
- Reset mid-operation: all of the above is restored in the next cycle and any pending shadow is lost.
- `en` while IDLE produces no output pulse. `phase_out` holds its last value.
- `ftw_act`=0 in RUN: phase is frozen and no wrap ever occurs. STOPPING then never completes until reset or a nonzero FTW is applied, which can only happen in IDLE. This is documented behaviour.

## Configuration
- `NCO_DITHER_EN` defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances on each step.
  - `dith = lfsr << (ACC_W-PHASE_W-8)`, i.e. occupies the 8 bits directly below the output LSB.
  - Breaks truncation spurs.
- Undefined: `dith`=0, no LFSR is instantiated, and output is pure truncation.

## Structure
- Package `nco_pkg`: `ACC_W`/`PHASE_W` defaults, state enum {IDLE, RUN, STOPPING}, LFSR seed and tap constants.
- Sub-module `nco_lfsr8`: step enable, synchronous reset to seed, 8-bit output. Instantiated only under `NCO_DITHER_EN`.

## Test plan
- **Reset:** `rst` during RUN with `shd_full`=1 → next cycle all outputs 0, `ftw_ready`=1, `busy`=0.
- **Basic step:** FTW 32'h0000_0800 loaded in IDLE, `start`, 4 strobes → `phase_out` 1,2,3,4; `phase_valid` ×4; `wrap`=0.
- **Half-rate wrap:** FTW 32'h8000_0000, offset 0, 4 strobes → `phase_out` 21'h100000, 0, 21'h100000, 0; `wrap` on 2nd and 4th.
- **Phase-continuous update:**
  - Setup: FTW 32'h4000_0000 running; load 32'h2000_0000 after strobe 1.
  - Required: `ftw_ready` low until the wrap at strobe 4; steps after the wrap add 21'h040000.
  - Second word: offered while `ftw_ready`=0 is not accepted.
- **Stop on wrap:** FTW 32'h4000_0000, `stop` after strobe 1 → strobes 2–4 output, `wrap` on 4, then `busy`=0 and further `en` gives no `phase_valid`.
- **Offset (dither off):** FTW 0, offset 21'h1FFFFF, `start`, strobe → `phase_out`=21'h1FFFFF. With FTW 32'h0000_0800 → next 21'h000000.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared constants and types for the NCO phase accumulator.
// Optional dither is enabled by defining NCO_DITHER_EN.
package nco_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int PHASE_W_DEF = 21;

  // Start/stop FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    RUN      = ST_RUN,
    STOPPING = ST_STOPPING
  } nco_state_e;

  // Dither LFSR: x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/nco_phase_acc_if.sv
// Control, tuning-word handshake and phase output bundle of the NCO.
interface nco_phase_acc_if
  import nco_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
);

  logic               en;
  logic               start;
  logic               stop;
  logic [ACC_W-1:0]   ftw_in;
  logic               ftw_valid;
  logic               ftw_ready;
  logic [PHASE_W-1:0] phase_offset;
  logic [PHASE_W-1:0] phase_out;
  logic               phase_valid;
  logic               wrap;
  logic               busy;

  modport master (
    output en, start, stop, ftw_in, ftw_valid, phase_offset,
    input  ftw_ready, phase_out, phase_valid, wrap, busy
  );

  modport slave (
    input  en, start, stop, ftw_in, ftw_valid, phase_offset,
    output ftw_ready, phase_out, phase_valid, wrap, busy
  );

endinterface

// File: rtl/nco_lfsr8.sv
// 8-bit Fibonacci LFSR used as phase dither; only built with NCO_DITHER_EN.
module nco_lfsr8
  import nco_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Advance one position per accumulator step
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // Register with synchronous reset to the seed
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/nco_phase_acc.sv
// Phase accumulator NCO with phase-continuous FTW update and whole-cycle stop.
// Define NCO_DITHER_EN to add LFSR dither below the output LSB.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | acc held at 0, strobes ignored, shadow FTW applied freely
// RUN      | one step per strobe; stop request moves to STOPPING
// STOPPING | keep stepping until the next carry, then clear acc, IDLE
module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
)(
  input logic             clk,
  input logic             rst,
  nco_phase_acc_if.slave  bus
);

  localparam int SHIFT = ACC_W - PHASE_W;

  if (SHIFT < 8) begin : g_bad_width
    $error("nco_phase_acc: ACC_W must be at least PHASE_W + 8");
  end

  logic [1:0]         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0]   ftw_shd_q, ftw_shd_d;
  logic               shd_full_q, shd_full_d;
  logic [PHASE_W-1:0] phase_out_q, phase_out_d;
  logic               phase_valid_q, phase_valid_d;
  logic               wrap_q, wrap_d;

  logic               step;
  logic               carry;
  logic               apply;
  logic               xfer;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   off_ext;
  logic [ACC_W-1:0]   dith;
  logic [ACC_W-1:0]   out_sum;

  assign step    = bus.en && (state_q == ST_RUN || state_q == ST_STOPPING);
  assign sum     = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign carry   = sum[ACC_W];
  assign off_ext = {bus.phase_offset, {SHIFT{1'b0}}};

`ifdef NCO_DITHER_EN
  logic [7:0] lfsr;

  nco_lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step_i (step),
    .lfsr_o (lfsr)
  );

  // Dither fills the 8 bits just below the output LSB
  assign dith = ACC_W'(lfsr) << (SHIFT - 8);
`else
  assign dith = '0;
`endif

  assign out_sum = sum[ACC_W-1:0] + off_ext + dith;

  // Shadow is applied at a wrap (phase-continuous) or at any time while idle
  assign apply = (step && carry) || (state_q == ST_IDLE);
  assign xfer  = bus.ftw_valid && !shd_full_q;

  // FSM, accumulator step and output formation
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    phase_out_d   = phase_out_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (step) acc_d = sum[ACC_W-1:0];
        if (bus.stop) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (step) begin
          acc_d = sum[ACC_W-1:0];
          if (carry) begin
            acc_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        acc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (step) begin
      phase_out_d   = out_sum[ACC_W-1 -: PHASE_W];
      phase_valid_d = 1'b1;
      wrap_d        = carry;
    end
  end

  // Tuning-word shadow: a same-cycle transfer wins over the apply clear
  always_comb begin
    ftw_act_d  = ftw_act_q;
    ftw_shd_d  = ftw_shd_q;
    shd_full_d = shd_full_q;
    if (apply) begin
      ftw_act_d  = ftw_shd_q;
      shd_full_d = 1'b0;
    end
    if (xfer) begin
      ftw_shd_d  = bus.ftw_in;
      shd_full_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      ftw_act_q     <= '0;
      ftw_shd_q     <= '0;
      shd_full_q    <= 1'b0;
      phase_out_q   <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      ftw_act_q     <= ftw_act_d;
      ftw_shd_q     <= ftw_shd_d;
      shd_full_q    <= shd_full_d;
      phase_out_q   <= phase_out_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  assign bus.ftw_ready   = !shd_full_q;
  assign bus.phase_out   = phase_out_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.wrap        = wrap_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed self-checking bench for nco_phase_acc (default build, no dither).
module tb_nco_phase_acc;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  nco_phase_acc_if #(.ACC_W(32), .PHASE_W(21)) bus ();

  nco_phase_acc #(.ACC_W(32), .PHASE_W(21)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Transfer a word while idle, then let the idle apply happen
  task automatic load_ftw(input logic [31:0] w);
    bus.ftw_in    = w;
    bus.ftw_valid = 1'b1;
    tick();
    bus.ftw_valid = 1'b0;
    tick();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic strobe();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
  endtask

  task automatic check_step(input string tag, input logic [31:0] ph, input logic wr);
    check({tag, "_phase"}, 32'(bus.phase_out), ph);
    check({tag, "_valid"}, 32'(bus.phase_valid), 32'd1);
    check({tag, "_wrap"}, 32'(bus.wrap), 32'(wr));
  endtask

  initial begin
    rst              = 1'b1;
    bus.en           = 1'b0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.ftw_in       = '0;
    bus.ftw_valid    = 1'b0;
    bus.phase_offset = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_phase", 32'(bus.phase_out), 32'd0);
    check("rst_valid", 32'(bus.phase_valid), 32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.ftw_ready), 32'd1);

    // Basic step: +1 output LSB per strobe
    load_ftw(32'h0000_0800);
    check("basic_ready", 32'(bus.ftw_ready), 32'd1);
    strobe();
    check("idle_en_valid", 32'(bus.phase_valid), 32'd0);
    do_start();
    check("basic_busy", 32'(bus.busy), 32'd1);
    strobe(); check_step("basic1", 32'h1, 1'b0);
    strobe(); check_step("basic2", 32'h2, 1'b0);
    strobe(); check_step("basic3", 32'h3, 1'b0);
    strobe(); check_step("basic4", 32'h4, 1'b0);
    tick();
    check("basic_pulse_end", 32'(bus.phase_valid), 32'd0);
    check("basic_hold", 32'(bus.phase_out), 32'h4);

    // Reset while running with a pending shadow
    bus.ftw_in    = 32'h1234_5678;
    bus.ftw_valid = 1'b1;
    tick();
    bus.ftw_valid = 1'b0;
    check("pend_ready", 32'(bus.ftw_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("rr_phase", 32'(bus.phase_out), 32'd0);
    check("rr_valid", 32'(bus.phase_valid), 32'd0);
    check("rr_wrap", 32'(bus.wrap), 32'd0);
    check("rr_busy", 32'(bus.busy), 32'd0);
    check("rr_ready", 32'(bus.ftw_ready), 32'd1);
    rst = 1'b0;
    tick();
    do_start();
    strobe(); check_step("rr_lost_shadow", 32'h0, 1'b0);

    // Half-rate wrap
    do_reset();
    load_ftw(32'h8000_0000);
    do_start();
    strobe(); check_step("half1", 32'h100000, 1'b0);
    strobe(); check_step("half2", 32'h000000, 1'b1);
    strobe(); check_step("half3", 32'h100000, 1'b0);
    strobe(); check_step("half4", 32'h000000, 1'b1);

    // Phase-continuous update at wrap
    do_reset();
    load_ftw(32'h4000_0000);
    do_start();
    strobe(); check_step("pc1", 32'h080000, 1'b0);
    bus.ftw_in    = 32'h2000_0000;
    bus.ftw_valid = 1'b1;
    tick();
    check("pc_ready_lo", 32'(bus.ftw_ready), 32'd0);
    bus.ftw_in = 32'h1000_0000;
    strobe(); check_step("pc2", 32'h100000, 1'b0);
    check("pc_ready2", 32'(bus.ftw_ready), 32'd0);
    strobe(); check_step("pc3", 32'h180000, 1'b0);
    check("pc_ready3", 32'(bus.ftw_ready), 32'd0);
    bus.ftw_valid = 1'b0;
    strobe(); check_step("pc4", 32'h000000, 1'b1);
    check("pc_ready4", 32'(bus.ftw_ready), 32'd1);
    strobe(); check_step("pc5", 32'h040000, 1'b0);
    strobe(); check_step("pc6", 32'h080000, 1'b0);

    // Stop lands on the next wrap
    do_reset();
    load_ftw(32'h4000_0000);
    do_start();
    strobe(); check_step("stop1", 32'h080000, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_busy_req", 32'(bus.busy), 32'd1);
    strobe(); check_step("stop2", 32'h100000, 1'b0);
    strobe(); check_step("stop3", 32'h180000, 1'b0);
    check("stop_busy3", 32'(bus.busy), 32'd1);
    strobe(); check_step("stop4", 32'h000000, 1'b1);
    check("stop_busy_end", 32'(bus.busy), 32'd0);
    strobe();
    check("stop_idle_valid", 32'(bus.phase_valid), 32'd0);

    // Start and stop together in IDLE: start wins
    do_reset();
    load_ftw(32'h8000_0000);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    strobe(); check_step("ss1", 32'h100000, 1'b0);
    strobe(); check_step("ss2", 32'h000000, 1'b1);
    check("ss_busy", 32'(bus.busy), 32'd1);

    // Offset with zero FTW, then offset wraparound
    do_reset();
    bus.phase_offset = 21'h1FFFFF;
    do_start();
    strobe(); check_step("off0", 32'h1FFFFF, 1'b0);
    do_reset();
    load_ftw(32'h0000_0800);
    do_start();
    strobe(); check_step("off1", 32'h000000, 1'b0);
    strobe(); check_step("off2", 32'h000001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
